// File: rtl/interconnect_fsm.sv
// interconnect_fsm: control sequencer for the PCIe QoS interconnect.
// Loads and validates the FIFO almost-full/almost-empty thresholds during
// INIT, drives the registered threshold buses, and reports IDLE/ACTIVE/ERROR
// status from the FIFO empty and error flags.
// Optional feature: define INTFSM_ERR_RECOVER_EN to allow leaving ERROR via
// init (with no error flags present) instead of only via reset.
module interconnect_fsm #(
    parameter int LEN4  = 4,
    parameter int LEN16 = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [2*LEN4-1:0]    cfg_main_in,
    input  logic [2*LEN16-1:0]   cfg_vc_in,
    input  logic [2*LEN4-1:0]    cfg_d_in,
    input  logic [4:0]           empty_vec,
    input  logic [4:0]           error_vec,
    output logic [2*LEN4-1:0]    cfg_main,
    output logic [2*LEN16-1:0]   cfg_vc,
    output logic [2*LEN4-1:0]    cfg_d,
    output logic [4:0]           state,
    output logic                 idle_out,
    output logic                 active_out,
    output logic                 error_out,
    output logic [4:0]           error_src,
    output logic                 cfg_bad
);

    typedef enum logic [4:0] {
        S_RESET  = 5'b00001,
        S_INIT   = 5'b00010,
        S_IDLE   = 5'b00100,
        S_ACTIVE = 5'b01000,
        S_ERROR  = 5'b10000
    } state_t;

    state_t              state_q, state_d;
    logic [2*LEN4-1:0]   cfg_main_q, cfg_main_d;
    logic [2*LEN16-1:0]  cfg_vc_q, cfg_vc_d;
    logic [2*LEN4-1:0]   cfg_d_q, cfg_d_d;
    logic [4:0]          error_src_q, error_src_d;
    logic                cfg_bad_q, cfg_bad_d;

    logic                cfg_ok;
    logic                err_any;
    logic                all_empty;

    // Threshold pair validity (LOW < HIGH, unsigned) and flag summaries.
    always_comb begin
        cfg_ok    = (cfg_main_in[LEN4-1:0]  < cfg_main_in[2*LEN4-1:LEN4]) &&
                    (cfg_vc_in[LEN16-1:0]   < cfg_vc_in[2*LEN16-1:LEN16]) &&
                    (cfg_d_in[LEN4-1:0]     < cfg_d_in[2*LEN4-1:LEN4]);
        err_any   = |error_vec;
        all_empty = (empty_vec == 5'b11111);
    end

    // Next-state, threshold capture and sticky error bookkeeping.
    always_comb begin
        state_d     = state_q;
        cfg_main_d  = cfg_main_q;
        cfg_vc_d    = cfg_vc_q;
        cfg_d_d     = cfg_d_q;
        error_src_d = error_src_q;
        cfg_bad_d   = cfg_bad_q;

        case (state_q)
            S_RESET: begin
                state_d = S_INIT;
            end
            S_INIT: begin
                if (cfg_ok) begin
                    cfg_main_d = cfg_main_in;
                    cfg_vc_d   = cfg_vc_in;
                    cfg_d_d    = cfg_d_in;
                    cfg_bad_d  = 1'b0;
                end else begin
                    cfg_bad_d  = 1'b1;
                end
                if (err_any) begin
                    state_d     = S_ERROR;
                    error_src_d = error_src_q | error_vec;
                end else if (!init && cfg_ok) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (err_any) begin
                    state_d     = S_ERROR;
                    error_src_d = error_src_q | error_vec;
                end else if (init) begin
                    state_d = S_INIT;
                end else if (!all_empty) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (err_any) begin
                    state_d     = S_ERROR;
                    error_src_d = error_src_q | error_vec;
                end else if (init) begin
                    state_d = S_INIT;
                end else if (all_empty) begin
                    state_d = S_IDLE;
                end
            end
            S_ERROR: begin
`ifdef INTFSM_ERR_RECOVER_EN
                if (init && !err_any) begin
                    state_d     = S_INIT;
                    error_src_d = 5'b00000;
                end else begin
                    error_src_d = error_src_q | error_vec;
                end
`else
                error_src_d = error_src_q | error_vec;
`endif
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    // State and configuration registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_RESET;
            cfg_main_q  <= '0;
            cfg_vc_q    <= '0;
            cfg_d_q     <= '0;
            error_src_q <= '0;
            cfg_bad_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_main_q  <= cfg_main_d;
            cfg_vc_q    <= cfg_vc_d;
            cfg_d_q     <= cfg_d_d;
            error_src_q <= error_src_d;
            cfg_bad_q   <= cfg_bad_d;
        end
    end

    assign state      = state_q;
    assign cfg_main   = cfg_main_q;
    assign cfg_vc     = cfg_vc_q;
    assign cfg_d      = cfg_d_q;
    assign error_src  = error_src_q;
    assign cfg_bad    = cfg_bad_q;
    assign idle_out   = (state_q == S_IDLE);
    assign active_out = (state_q == S_ACTIVE);
    assign error_out  = (state_q == S_ERROR);

endmodule
